// File: rtl/count_scan_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | count_scan_ctrl_pkg : shared constants and 7-segment decoder table         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package count_scan_ctrl_pkg;

  localparam int         DIGIT_W   = 4;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  // Active-low {g,f,e,d,c,b,a}; A-F shown as A b C d E F
  function automatic logic [6:0] seg_decode(input logic [DIGIT_W-1:0] v);
    logic [6:0] s;
    s = SEG_BLANK;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/count_scan_ctrl_digit_cnt.sv
// +----------------------------------------------------------------------------+
// | digit_cnt : one 4-bit modulo-MODULO digit with synchronous clear           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module digit_cnt
  import count_scan_ctrl_pkg::*;
#(
  parameter int MODULO = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               clr,
  output logic [DIGIT_W-1:0] q,
  output logic               at_max
);

  localparam logic [DIGIT_W-1:0] MAX_VAL = DIGIT_W'(MODULO - 1);

  logic [DIGIT_W-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc) begin
      q_d = (q_q == MAX_VAL) ? '0 : q_q + DIGIT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q      = q_q;
  assign at_max = (q_q == MAX_VAL);

endmodule

`default_nettype wire

// File: rtl/count_scan_ctrl.sv
// +----------------------------------------------------------------------------+
// | count_scan_ctrl : prescaled cascaded digit counter with scanned 7-seg out  |
// | Optional macro SCAN_BLANK_EN enables leading-zero blanking.                |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module count_scan_ctrl
  import count_scan_ctrl_pkg::*;
#(
  parameter int MODULO   = 5,
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 4,
  parameter int SCAN_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              tick,
  output logic              wrap
);

  localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SDIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SLOT_W = (DIGITS > 1)   ? $clog2(DIGITS)   : 1;

  localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(PRESCALE - 1);
  localparam logic [SDIV_W-1:0] SDIV_MAX = SDIV_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(DIGITS - 1);

  logic [PRE_W-1:0]  pre_d,  pre_q;
  logic [SDIV_W-1:0] sdiv_d, sdiv_q;
  logic [SLOT_W-1:0] slot_d, slot_q;
  logic [DIGITS-1:0] an_d,   an_q;
  logic [6:0]        seg_d,  seg_q;
  logic              wrap_d, wrap_q;

  logic [DIGITS:0]                 carry;
  logic [DIGITS-1:0]               at_max;
  logic [DIGITS-1:0][DIGIT_W-1:0]  digit_val;
  logic [DIGIT_W-1:0]              digit_sel;

  // clr masks tick so a coincident clear can never ripple or raise wrap
  assign tick     = en & (pre_q == PRE_MAX) & ~clr;
  assign carry[0] = tick;

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      digit_cnt #(.MODULO(MODULO)) u_digit (
        .clk    (clk),
        .rst    (rst),
        .inc    (carry[i]),
        .clr    (clr),
        .q      (digit_val[i]),
        .at_max (at_max[i])
      );
      assign carry[i+1] = carry[i] & at_max[i];
    end
  endgenerate

`ifdef SCAN_BLANK_EN
  // hi_zero[i]: digit i and every digit above it are zero
  logic [DIGITS:1] hi_zero;
  logic            blank_sel;
  assign hi_zero[DIGITS] = 1'b1;
  generate
    for (genvar i = 1; i < DIGITS; i++) begin : g_hi_zero
      assign hi_zero[i] = hi_zero[i+1] & (digit_val[i] == '0);
    end
  endgenerate
`endif

  always_comb begin
    digit_sel = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (slot_q == SLOT_W'(i)) begin
        digit_sel = digit_val[i];
      end
    end
  end

`ifdef SCAN_BLANK_EN
  always_comb begin
    blank_sel = 1'b0;
    for (int i = 1; i < DIGITS; i++) begin
      if (slot_q == SLOT_W'(i)) begin
        blank_sel = hi_zero[i];
      end
    end
  end
`endif

  always_comb begin
    pre_d = pre_q;
    if (clr) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + PRE_W'(1);
    end

    sdiv_d = (sdiv_q == SDIV_MAX) ? '0 : sdiv_q + SDIV_W'(1);
    slot_d = slot_q;
    if (sdiv_q == SDIV_MAX) begin
      slot_d = (slot_q == SLOT_MAX) ? '0 : slot_q + SLOT_W'(1);
    end

    for (int i = 0; i < DIGITS; i++) begin
      an_d[i] = (slot_q == SLOT_W'(i));
    end

`ifdef SCAN_BLANK_EN
    seg_d = blank_sel ? SEG_BLANK : seg_decode(digit_sel);
`else
    seg_d = seg_decode(digit_sel);
`endif

    wrap_d = carry[DIGITS];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q  <= '0;
      sdiv_q <= '0;
      slot_q <= '0;
      an_q   <= DIGITS'(1);
      seg_q  <= SEG_ZERO;
      wrap_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      sdiv_q <= sdiv_d;
      slot_q <= slot_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      wrap_q <= wrap_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign wrap = wrap_q;

endmodule

`default_nettype wire
